// File: rtl/fd_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : fd_delay_line
// Purpose  : WIDTH x DEPTH registered delay line with clock enable, sync/async
//            clear, global reset hookup and a saturating fill-valid flag.
//            Optional TAPS port enabled by `define FD_DELAY_TAPS_EN.
// Revision : 1.0  initial release
// ============================================================================
module fd_delay_line #(
   parameter string            GSR   = "ENABLED",
   parameter int               WIDTH = 8,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic                     CK,
   input  logic                     CD,
   input  logic                     SP,
   input  logic                     LSR,
   input  logic [WIDTH-1:0]         D,
   output wire  [WIDTH-1:0]         Q,
   output logic                     QV
`ifdef FD_DELAY_TAPS_EN
   ,
   output logic [WIDTH*DEPTH-1:0]   TAPS
`endif
);

   localparam int                 c_cnt_w  = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
   localparam logic               c_gsr_en = (GSR == "ENABLED");

   // Global reset nets, low-true and inactive unless forced from outside.
   if (1) begin : GSR_INST
      wire GSRNET;
      assign GSRNET = 1'b1;
   end

   if (1) begin : PUR_INST
      wire PURNET;
      assign PURNET = 1'b1;
   end

   logic [DEPTH-1:0][WIDTH-1:0] r_stage;
   logic [DEPTH-1:0][WIDTH-1:0] w_shift;
   logic [c_cnt_w-1:0]          r_count;
   logic [c_cnt_w-1:0]          w_cnt_inc;
   logic                        r_qv;
   logic                        w_rst;

   assign w_rst = CD | ~PUR_INST.PURNET | (c_gsr_en & ~GSR_INST.GSRNET);

   assign w_shift[0] = D;
   for (genvar k = 1; k < DEPTH; k++) begin : g_shift
      assign w_shift[k] = r_stage[k-1];
   end

   assign w_cnt_inc = (r_count == c_depth) ? r_count : r_count + 1'b1;

   // Ternaries (not if/else) so an unknown LSR/SP merges to X instead of holding.
   always_ff @(posedge CK or posedge w_rst) begin
      if (w_rst) begin
         r_stage <= {DEPTH{INIT}};
         r_count <= '0;
         r_qv    <= 1'b0;
      end else begin
         r_stage <= LSR ? {DEPTH{INIT}} : (SP ? w_shift : r_stage);
         r_count <= LSR ? '0 : (SP ? w_cnt_inc : r_count);
         r_qv    <= LSR ? 1'b0 : (SP ? (w_cnt_inc == c_depth) : r_qv);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_qbuf
      buf u_qbuf (Q[i], r_stage[DEPTH-1][i]);
   end

   assign QV = r_qv;

`ifdef FD_DELAY_TAPS_EN
   assign TAPS = r_stage;
`endif

endmodule
`default_nettype wire
